// File: rtl/sum3_pipe.sv
// Two-stage pipelined per-channel x + y + a adder with running accumulation and overflow flag.
// Build option: define SUM3_SAT_EN for unsigned saturation instead of wrap-around.

module sum3_lane #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld1,
  input  logic         ld2,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] a,
  input  logic         acc_en,
  input  logic         acc_clr,
  output logic [W-1:0] sum,
  output logic         ovf
);
  typedef struct packed {
    logic [W:0]   xy;
    logic [W-1:0] a;
    logic         en;
    logic         clr;
  } s1_t;

  s1_t          s1_q;
  logic [W+1:0] full;
  logic [W-1:0] sum_n;

  // The accumulator is always the last loaded result, so the S2 sum register doubles as acc.
  always_comb begin
    full = {1'b0, s1_q.xy} + {2'b00, s1_q.a};
    if (s1_q.en && !s1_q.clr) full = full + {2'b00, sum};
  end

`ifdef SUM3_SAT_EN
  assign sum_n = (full[W+1:W] != 2'b00) ? '1 : full[W-1:0];
`else
  assign sum_n = full[W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      sum  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (ld1) begin
        s1_q.xy  <= {1'b0, x} + {1'b0, y};
        s1_q.a   <= a;
        s1_q.en  <= acc_en;
        s1_q.clr <= acc_clr;
      end
      if (ld2) begin
        sum <= sum_n;
        ovf <= |full[W+1:W];
      end
    end
  end
endmodule

module sum3_pipe #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_x,
  input  logic [CHANNELS*WIDTH-1:0] in_y,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS-1:0]       in_acc_en,
  input  logic [CHANNELS-1:0]       in_acc_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_sum,
  output logic [CHANNELS-1:0]       out_ovf
);
  localparam int STAGES = 2;

  logic [STAGES:1]                    vld_pipe;
  logic                               s2_adv, ld1, ld2;
  logic [CHANNELS-1:0][WIDTH-1:0]     x_l, y_l, a_l, sum_l;

  // in_ready looks only at stage state and out_ready, never at in_valid.
  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || s2_adv;
  assign ld1       = in_ready && in_valid;
  assign ld2       = s2_adv && vld_pipe[1];
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s2_adv)   vld_pipe[2] <= vld_pipe[1];
    end
  end

  assign x_l     = in_x;
  assign y_l     = in_y;
  assign a_l     = in_a;
  assign out_sum = sum_l;

  sum3_lane #(.W(WIDTH)) u_lane [CHANNELS-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld1     (ld1),
    .ld2     (ld2),
    .x       (x_l),
    .y       (y_l),
    .a       (a_l),
    .acc_en  (in_acc_en),
    .acc_clr (in_acc_clr),
    .sum     (sum_l),
    .ovf     (out_ovf)
  );
endmodule
